// File: rtl/rv_mul_unit.sv
// Iterative RV32M multiplier: accumulates ASLICE x BSLICE unsigned partial products on operand
// magnitudes, then applies the sign fix-up and selects the requested result half.
module rv_mul_unit #(
  parameter int unsigned DPWIDTH = 32,
  parameter int unsigned ASLICE  = 8,
  parameter int unsigned BSLICE  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [DPWIDTH-1:0] op_a,
  input  logic [DPWIDTH-1:0] op_b,
  output logic               busy,
  output logic               done,
  output logic [DPWIDTH-1:0] result
);

  localparam int unsigned NA = DPWIDTH / ASLICE;
  localparam int unsigned NB = DPWIDTH / BSLICE;
  localparam int unsigned PW = 2 * DPWIDTH;
  localparam int unsigned AW = (NA > 1) ? $clog2(NA) : 1;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned SW = ASLICE + BSLICE;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic [DPWIDTH-1:0] a_q, b_q;
  logic               neg_q;
  logic [PW-1:0]      prod_q;
  logic [AW-1:0]      ai_q;
  logic [BW-1:0]      bi_q;
  logic [DPWIDTH-1:0] result_q;

  logic               a_neg, b_neg;
  logic [DPWIDTH-1:0] a_mag, b_mag;
  logic [ASLICE-1:0]  a_slice;
  logic [BSLICE-1:0]  b_slice;
  logic [31:0]        a_sh, b_sh, shamt;
  logic [SW-1:0]      pp;
  logic [PW-1:0]      pp_sh;
  logic               last_a, last_b;

  // Operands are only treated as two's complement where the mode makes them signed.
  always_comb begin
    a_neg = (mode == 2'b01 || mode == 2'b10) && op_a[DPWIDTH-1];
    b_neg = (mode == 2'b01) && op_b[DPWIDTH-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  always_comb begin
    a_sh    = 32'(ai_q) * ASLICE;
    b_sh    = 32'(bi_q) * BSLICE;
    shamt   = a_sh + b_sh;
    a_slice = ASLICE'(a_q >> a_sh);
    b_slice = BSLICE'(b_q >> b_sh);
    pp      = {{BSLICE{1'b0}}, a_slice} * {{ASLICE{1'b0}}, b_slice};
    pp_sh   = PW'(pp) << shamt;
    last_a  = (ai_q == AW'(NA - 1));
    last_b  = (bi_q == BW'(NB - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (last_a && last_b) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    result = result_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q   <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      ai_q     <= '0;
      bi_q     <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mode_q <= mode;
            a_q    <= a_mag;
            b_q    <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            prod_q <= '0;
            ai_q   <= '0;
            bi_q   <= '0;
          end
        end
        StCalc: begin
          prod_q <= prod_q + pp_sh;
          if (last_a) begin
            ai_q <= '0;
            bi_q <= last_b ? '0 : bi_q + BW'(1);
          end else begin
            ai_q <= ai_q + AW'(1);
          end
        end
        StFix: begin
          if (neg_q) prod_q <= -prod_q;
        end
        StDone: begin
          result_q <= (mode_q == 2'b00) ? prod_q[DPWIDTH-1:0] : prod_q[PW-1:DPWIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mul_unit.sv
// Bench for rv_mul_unit: a default 32-bit instance and a 16/4/8 instance, checked against
// directed constants and an integer-arithmetic reference model.
module tb_rv_mul_unit;

  localparam int NIT32 = (32 / 8) * (32 / 16);
  localparam int NIT16 = (16 / 4) * (16 / 8);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start32 = 1'b0, start16 = 1'b0;
  logic [1:0]  mode32 = 2'b00, mode16 = 2'b00;
  logic [31:0] op_a32 = '0, op_b32 = '0, result32;
  logic [15:0] op_a16 = '0, op_b16 = '0, result16;
  logic        busy32, done32, busy16, done16;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev32 = '0, prev16 = '0;

  always #5 clk = ~clk;

  rv_mul_unit dut32 (
    .clk(clk), .rst(rst), .start(start32), .mode(mode32), .op_a(op_a32), .op_b(op_b32),
    .busy(busy32), .done(done32), .result(result32)
  );

  rv_mul_unit #(.DPWIDTH(16), .ASLICE(4), .BSLICE(8)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .op_a(op_a16), .op_b(op_b16),
    .busy(busy16), .done(done16), .result(result16)
  );

  // Directed cases: mode, op_a, op_b, expected result.
  logic [1:0]  d32_m [8] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [31:0] d32_a [8] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                             32'h80000000, 32'hFFFFFFFF, 32'h2};
  logic [31:0] d32_b [8] = '{32'h6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1,
                             32'h1, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] d32_e [8] = '{32'h2A, 32'h1, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
  logic [1:0]  d16_m [3] = '{2'd0, 2'd3, 2'd1};
  logic [31:0] d16_a [3] = '{32'h1234, 32'h1234, 32'hFFFE};
  logic [31:0] d16_b [3] = '{32'h5678, 32'h5678, 32'h0003};
  logic [31:0] d16_e [3] = '{32'h0060, 32'h0626, 32'hFFFF};

  // Reference: exact signed/unsigned integer product of w-bit operands, then half select.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic signed [127:0] ea, eb, p;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    ea = '0;
    eb = '0;
    ea[31:0] = a & mask;
    eb[31:0] = b & mask;
    if ((m == 2'b01 || m == 2'b10) && a[w-1]) ea = ea - (128'sd1 <<< w);
    if (m == 2'b01 && b[w-1]) eb = eb - (128'sd1 <<< w);
    p = ea * eb;
    if (m == 2'b00) return 32'(p) & mask;
    return 32'(p >>> w) & mask;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation on the selected instance; with hold, start stays high and the inputs keep
  // changing while the unit is busy (including the DONE cycle).
  task automatic do_op(input bit sel, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit hold,
                       input string tag);
    int nit;
    logic [31:0] prev;
    nit  = sel ? NIT16 : NIT32;
    prev = sel ? prev16 : prev32;
    @(negedge clk);
    if (sel) begin
      start16 = 1'b1; mode16 = m; op_a16 = a[15:0]; op_b16 = b[15:0];
    end else begin
      start32 = 1'b1; mode32 = m; op_a32 = a; op_b32 = b;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      start16 = 1'b0;
      start32 = 1'b0;
    end
    for (int k = 1; k <= nit + 2; k++) begin
      @(negedge clk);
      if (hold) begin
        mode16 = 2'($urandom); op_a16 = 16'($urandom); op_b16 = 16'($urandom);
        mode32 = 2'($urandom); op_a32 = $urandom;      op_b32 = $urandom;
      end
      chk({tag, "/busy"}, 32'(sel ? busy16 : busy32), 32'd1);
      chk({tag, "/done"}, 32'(sel ? done16 : done32), 32'(k == nit + 2));
      if (k == 1 || k == nit + 2)
        chk({tag, "/held"}, sel ? {16'h0, result16} : result32, prev);
    end
    @(negedge clk);
    chk({tag, "/idle"}, 32'(sel ? busy16 : busy32), 32'd0);
    chk({tag, "/nodone"}, 32'(sel ? done16 : done32), 32'd0);
    chk({tag, "/result"}, sel ? {16'h0, result16} : result32, exp);
    start16 = 1'b0;
    start32 = 1'b0;
    if (sel) prev16 = exp;
    else     prev32 = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m;
    logic [31:0] a, b;
    int          w;
    bit          sel;

    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/busy32", 32'(busy32), 32'd0);
    chk("rst/done32", 32'(done32), 32'd0);
    chk("rst/result32", result32, 32'd0);
    chk("rst/busy16", 32'(busy16), 32'd0);
    chk("rst/result16", {16'h0, result16}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) do_op(1'b0, d32_m[i], d32_a[i], d32_b[i], d32_e[i], 1'b0, "dir32");
    for (int i = 0; i < 3; i++) do_op(1'b1, d16_m[i], d16_a[i], d16_b[i], d16_e[i], 1'b0, "dir16");

    // Start held high with changing operands must not disturb the accepted operation.
    do_op(1'b0, 2'b00, 32'h7, 32'h6, 32'h2A, 1'b1, "hold32");
    do_op(1'b1, 2'b11, 32'h1234, 32'h5678, 32'h0626, 1'b1, "hold16");

    // Reset in cycle 4 of MUL 3x5 abandons it.
    @(negedge clk);
    start32 = 1'b1; mode32 = 2'b00; op_a32 = 32'd3; op_b32 = 32'd5;
    @(posedge clk);
    #1 start32 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("abort/busy", 32'(busy32), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort/busy_after", 32'(busy32), 32'd0);
    chk("abort/done_after", 32'(done32), 32'd0);
    chk("abort/result", result32, 32'd0);
    rst = 1'b1;
    prev32 = '0;
    prev16 = '0;
    for (int k = 0; k < NIT32 + 2; k++) begin
      @(negedge clk);
      chk("abort/nodone", 32'(done32), 32'd0);
    end

    // Randomised operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      sel = (i % 2) == 1;
      w   = sel ? 16 : 32;
      m   = 2'($urandom);
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: a = sel ? 32'h8000 : 32'h80000000;
        1: b = sel ? 32'hFFFF : 32'hFFFFFFFF;
        2: begin a = sel ? 32'h8000 : 32'h80000000; b = a; end
        default: ;
      endcase
      do_op(sel, m, a, b, model(m, a, b, w), 1'($urandom), sel ? "rnd16" : "rnd32");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_mul_unit.md
# rv_mul_unit

Parametrised iterative multiplier for the multicycle RISC-V core, owning its own sequencing FSM instead of relying on per-cycle slice, shift and product-update strobes from the control unit. It computes a DPWIDTH×DPWIDTH product by accumulating ASLICE×BSLICE partial products, one per cycle, into a 2·DPWIDTH product register. It supports the four RV32M multiply modes through a start/busy/done handshake. It sits beside the ALU in the datapath; the control FSM stalls in its execute state until `done`.

## Interface

Parameters:
- DPWIDTH, 32, operand and result width
- ASLICE, 8, operand A slice width; DPWIDTH must be a multiple of ASLICE
- BSLICE, 16, operand B slice width; DPWIDTH must be a multiple of BSLICE

Derived values:
- NA = DPWIDTH/ASLICE
- NB = DPWIDTH/BSLICE
- NIT = NA·NB

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- op_a  in  DPWIDTH  multiplicand (rs1)
- op_b  in  DPWIDTH  multiplier (rs2)
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; result valid
- result  out  DPWIDTH  registered result; held until the next accepted start

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE:** with start=1, on the clock edge:
  - latch mode;
  - latch unsigned magnitudes of op_a and op_b (operand taken as two's complement only where the mode treats it as signed);
  - latch neg flag (MULH: op_a[MSB]^op_b[MSB]; MULHSU: op_a[MSB]; MUL and MULHU: 0);
  - clear the product register and both slice counters ai, bi;
  - go to CALC.
- **CALC:** each cycle, product += (A slice ai × B slice bi) << (ai·ASLICE + bi·BSLICE).
  - The partial product is ASLICE+BSLICE bits wide, unsigned.
  - Accumulation is 2·DPWIDTH wide; no overflow is possible.
  - ai increments fastest and wraps at NA-1, then bi increments.
  - After the iteration with ai=NA-1 and bi=NB-1, go to FIX.
- **FIX:** if neg, product = two's-complement negation modulo 2^(2·DPWIDTH). Go to DONE.
- **DONE:** done=1. result is loaded with product[DPWIDTH-1:0] for MUL, else product[2·DPWIDTH-1:DPWIDTH]. Go to IDLE.
- The magnitude of the most-negative value (0x80000000) is 2^(DPWIDTH-1). It is representable unsigned and requires no special case.
- start while busy is ignored; the operation in flight is unaffected.
- Operands and mode may change after the accepting edge without effect.

## Timing

- Reset (rst=0 at an edge) forces, on that edge:
  - state IDLE;
  - busy=0, done=0;
  - result=0, product=0;
  - ai=bi=0.
- Reset mid-operation abandons the operation: no done pulse, result=0.
- With start sampled at the edge ending cycle 0:
  - cycles 1..NIT are CALC;
  - cycle NIT+1 is FIX;
  - cycle NIT+2 is DONE (done=1).
- Latency is NIT+2 cycles: 10 for the defaults.
- result updates at the end of DONE and is valid from cycle NIT+3 onward. done is combinational from state==DONE; result is a register.
- The caller must capture result in the cycle after done, or at any later time before the next start.
- busy=1 in cycles 1..NIT+2.
- The earliest next start is accepted in cycle NIT+3. A start in the DONE cycle is ignored.
- Throughput is one operation per NIT+3 cycles with back-to-back starts.

## Test plan

- **MUL latency:** MUL op_a=7, op_b=6 at cycle 0 -> busy=1 in cycles 1–10; done=1 in cycle 10 only; result=0x0000002A from cycle 11.
- **Unsigned extremes:** MUL 0xFFFFFFFF×0xFFFFFFFF -> result=0x00000001. MULHU with the same operands -> result=0xFFFFFFFE.
- **Signed high half:** MULH 0x80000000×0x80000000 -> 0x40000000. MULH 0xFFFFFFFF×0x00000001 -> 0xFFFFFFFF. MULH 0x80000000×0x00000001 -> 0xFFFFFFFF.
- **Mixed sign:** MULHSU 0xFFFFFFFF×0xFFFFFFFF -> product 0xFFFFFFFF00000001, result=0xFFFFFFFF. MULHSU 0x00000002×0x80000000 -> 0x00000001.
- **Handshake and reset:**
  - start held high with new operands during cycles 1–10 -> ignored; result matches the first operands.
  - rst=0 in cycle 4 of a MUL 3×5 -> busy=0 and result=0 next cycle; no done pulse.
- **Parameter sweep:** DPWIDTH=16, ASLICE=4, BSLICE=8 (NIT=8):
  - MUL 0x1234×0x5678 -> 0x0060, done in cycle 10;
  - MULHU 0x1234×0x5678 -> 0x0626;
  - MULH 0xFFFE×0x0003 -> 0xFFFF.
